inst_loader: RTL

- Write-side counterpart of the instruction fetch path.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver or a bench driver.
- Assembles big-endian 32-bit MIPS instruction words and writes them sequentially into the instruction memory, starting at word address 0.
- Holds the CPU core in reset until the image is fully loaded, then releases it so fetch begins at PC 0.

---
 rtl/inst_loader_pkg.sv | 21 ++
 rtl/inst_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared types and constants for the instruction loader
//
// Purpose: loader FSM state encoding and the byte-stream framing constants.
// Ports: none (package).

package inst_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream instruction image loader for the MIPS core
//
// Purpose: receives a 2-byte big-endian word count N followed by N big-endian
// 32-bit words, writes them to instruction memory from word address 0 and holds
// the CPU in reset until the image is in place.
// Optional feature macro: INST_LOADER_CHECKSUM_EN (adds a trailing XOR checksum
// byte, checked in the CHECK state).
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   byte_i        stream byte
//   byte_valid_i  byte_i valid
//   byte_ready_o  loader accepts byte_i (registered state decode)
//   reload_i      restart loading from DONE or ERR
//   mem_we_o      instruction memory write enable
//   mem_addr_o    word write address
//   mem_wdata_o   word write data
//   cpu_rst_o     active-high CPU reset
//   done_o        image loaded
//   err_o         load aborted

module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic                  reload_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  cpu_rst_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Largest legal word count; 17 bits so that a 16-bit N compares cleanly.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHECK;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [ADDR_WIDTH:0]     word_q, word_d;
  logic [1:0]              bidx_q, bidx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    ready_q, we_q, we_d, cpu_rst_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [15:0]             n_full;
  logic [ADDR_WIDTH:0]     word_inc;
  logic                    xfer;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]              xor_q, xor_d;
`endif

  assign xfer     = byte_valid_i & ready_q;
  assign n_full   = {len_q[15:8], byte_i};
  assign word_inc = word_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef INST_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      LEN_HI: if (xfer) begin
        len_d[15:8] = byte_i;
        state_d     = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        len_d[7:0] = byte_i;
        word_d     = '0;
        bidx_d     = '0;
        if (n_full == 16'd0)             state_d = END_ST;
        else if ({1'b0, n_full} > DEPTH) state_d = ERR;
        else                             state_d = DATA;
      end
      DATA: if (xfer) begin
        shift_d = {shift_q[DATA_WIDTH-9:0], byte_i};
        bidx_d  = bidx_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
        xor_d   = xor_q ^ byte_i;
`endif
        // Word complete: present it on the memory port during the WRITE cycle.
        if (bidx_q == 2'(BYTES_PER_WORD - 1)) begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = word_q[ADDR_WIDTH-1:0];
          wdata_d = shift_d;
        end
      end
      WRITE: begin
        word_d  = word_inc;
        state_d = (16'(word_inc) == len_q) ? END_ST : DATA;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CHECK: if (xfer) begin
        state_d = (byte_i == xor_q) ? DONE : ERR;
      end
`endif
      DONE, ERR: if (reload_i) begin
        state_d = LEN_HI;
        len_d   = '0;
        word_d  = '0;
        bidx_d  = '0;
        shift_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
        xor_d   = '0;
`endif
      end
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LEN_HI;
      len_q     <= '0;
      word_q    <= '0;
      bidx_q    <= '0;
      shift_q   <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      word_q    <= word_d;
      bidx_q    <= bidx_d;
      shift_q   <= shift_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      // Status outputs decode the next state so they change on the entering edge.
      ready_q   <= (state_d == LEN_HI) || (state_d == LEN_LO) ||
                   (state_d == DATA)   || (state_d == CHECK);
      cpu_rst_q <= (state_d != DONE);
      done_q    <= (state_d == DONE);
      err_q     <= (state_d == ERR);
`ifdef INST_LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign byte_ready_o = ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
